snapshot_mem_bridge: RTL and testbench



---
 rtl/snapshot_mem_bridge.sv | 198 +++++++++++++++++++
 tb/tb_snapshot_mem_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_mem_bridge.sv
// Register-to-memory bridge: wide memory entries are accessed through DATA_WIDTH
// partitions staged in a local snapshot, with commit/read traffic to memory and an ack timeout.
module snapshot_mem_bridge #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    MEM_WIDTH      = 72,
    parameter int                    ADDR_WIDTH     = 12,
    parameter int                    ENTRY_WIDTH    = 6,
    parameter bit                    SUB            = 1'b0,
    parameter int unsigned           BASE           = 0,
    parameter bit                    WR_COMMIT_HIGH = 1'b0,
    parameter int unsigned           TIMEOUT        = 255,
    parameter logic [MEM_WIDTH-1:0]  RST_VALUE      = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mst__fsm__sync_reset,
    input  logic                    req_vld,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    ack_vld,
    output logic                    err,
    input  logic                    entry_vld,
    input  logic                    entry_write_protect_en,
    output logic                    mem_req_vld,
    input  logic                    mem_ack_vld,
    output logic [ENTRY_WIDTH-1:0]  mem_addr,
    output logic                    mem_rd_en,
    output logic                    mem_wr_en,
    output logic [MEM_WIDTH-1:0]    mem_wr_data,
    input  logic [MEM_WIDTH-1:0]    mem_rd_data
);

    localparam int unsigned PART_CNT  = (MEM_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int unsigned PAD_W     = PART_CNT * DATA_WIDTH;
    localparam int unsigned BYTE_BITS = $clog2(DATA_WIDTH / 8);
    localparam int unsigned PB        = $clog2(PART_CNT);
    localparam int unsigned PIW       = (PB > 0) ? PB : 1;
    localparam int unsigned COMMIT_P  = WR_COMMIT_HIGH ? PART_CNT - 1 : 0;
    localparam int unsigned CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        OP_DATA = 4'b0010,
        MEM_ACC = 4'b0100,
        RESP    = 4'b1000
    } state_t;

    state_t                 r_state;
    logic [MEM_WIDTH-1:0]   r_snap;
    logic                   r_rd;
    logic [PIW-1:0]         r_part;
    logic [ENTRY_WIDTH-1:0] r_entry;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ack;
    logic                   r_err;
    logic                   r_mem_req;
    logic                   r_mem_rd;
    logic                   r_mem_wr;

    logic [ADDR_WIDTH-1:0]  w_vaddr;
    logic [ADDR_WIDTH-1:0]  w_shift;
    logic [PIW-1:0]         w_part;
    logic [ENTRY_WIDTH-1:0] w_entry;
    logic                   w_is_wr;
    logic                   w_is_rd;
    logic                   w_mem_rd;
    logic                   w_mem_wr;
    logic [PAD_W-1:0]       w_snap_pad;
    logic [PAD_W-1:0]       w_stage_pad;
    logic [PAD_W-1:0]       w_commit_pad;
    logic [DATA_WIDTH-1:0]  w_sel;
    logic                   w_unused;

    assign w_vaddr = SUB ? (addr - ADDR_WIDTH'(BASE)) : addr;
    assign w_shift = w_vaddr >> BYTE_BITS;
    assign w_part  = PIW'(w_shift & ADDR_WIDTH'((1 << PB) - 1));
    assign w_entry = w_shift[PB +: ENTRY_WIDTH];

    // A simultaneous write+read is a write.
    assign w_is_wr  = wr_en;
    assign w_is_rd  = rd_en & ~wr_en;
    assign w_mem_rd = w_is_rd && (w_part == '0) && entry_vld;
    assign w_mem_wr = w_is_wr && (w_part == PIW'(COMMIT_P)) && !entry_write_protect_en;

    assign w_snap_pad = PAD_W'(r_snap);

    always_comb begin
        w_stage_pad  = w_snap_pad;
        w_commit_pad = w_snap_pad;
        w_sel        = '0;
        for (int unsigned p = 0; p < PART_CNT; p++) begin
            if (w_part == PIW'(p))
                w_stage_pad[p*DATA_WIDTH +: DATA_WIDTH] = wr_data;
            if (r_part == PIW'(p))
                w_sel = w_snap_pad[p*DATA_WIDTH +: DATA_WIDTH];
        end
        w_commit_pad[COMMIT_P*DATA_WIDTH +: DATA_WIDTH] = r_wdata;
    end

    assign w_unused = ^{w_shift, w_stage_pad, w_commit_pad};

    assign mem_wr_data = w_commit_pad[MEM_WIDTH-1:0];
    assign mem_req_vld = r_mem_req;
    assign mem_rd_en   = r_mem_rd;
    assign mem_wr_en   = r_mem_wr;
    assign mem_addr    = r_mem_req ? r_entry : '0;
    assign ack_vld     = r_ack;
    assign err         = r_err;
    assign rd_data     = (r_ack && r_rd && !r_err) ? w_sel : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_snap    <= '0;
            r_rd      <= 1'b0;
            r_part    <= '0;
            r_entry   <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
        end else if (mst__fsm__sync_reset) begin
            // Abort keeps the snapshot; only control state is dropped.
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_mem_req <= 1'b0;
            r_mem_rd  <= 1'b0;
            r_mem_wr  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_vld) begin
                        r_rd    <= w_is_rd;
                        r_part  <= w_part;
                        r_entry <= w_entry;
                        r_wdata <= wr_data;
                        r_err   <= 1'b0;
                        if (w_mem_rd || w_mem_wr) begin
                            r_state   <= MEM_ACC;
                            r_cnt     <= '0;
                            r_mem_req <= 1'b1;
                            r_mem_rd  <= w_mem_rd;
                            r_mem_wr  <= w_mem_wr;
                        end else begin
                            r_state <= OP_DATA;
                            r_ack   <= 1'b1;
                            if (w_is_wr)
                                r_snap <= w_stage_pad[MEM_WIDTH-1:0];
                            else if (w_is_rd && (w_part == '0))
                                r_snap <= RST_VALUE;
                        end
                    end
                end
                OP_DATA: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                MEM_ACC: begin
                    // A memory ack in the timeout cycle takes precedence.
                    if (mem_ack_vld) begin
                        r_snap    <= r_rd ? mem_rd_data : mem_wr_data;
                        r_state   <= RESP;
                        r_ack     <= 1'b1;
                        r_err     <= 1'b0;
                        r_mem_req <= 1'b0;
                        r_mem_rd  <= 1'b0;
                        r_mem_wr  <= 1'b0;
                    end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT))) begin
                        r_state   <= RESP;
                        r_ack     <= 1'b1;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_mem_rd  <= 1'b0;
                        r_mem_wr  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snapshot_mem_bridge.sv
// Scoreboard bench for snapshot_mem_bridge: a partition-level model predicts acks and
// memory requests; a monitor compares them as the DUT presents them.
module tb_snapshot_mem_bridge;

    localparam int             DW    = 32;
    localparam int             MW    = 72;
    localparam int             AW    = 12;
    localparam int             EW    = 6;
    localparam int             TO    = 4;
    localparam logic [AW-1:0]  BASEA = 12'h400;
    localparam logic [MW-1:0]  RSTV  = 72'h5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync_rst = 1'b0;
    logic          req_vld = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          ack_vld;
    logic          err;
    logic          entry_vld = 1'b0;
    logic          wp = 1'b0;
    logic          mem_req_vld;
    logic          mem_ack_vld = 1'b0;
    logic [EW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [MW-1:0] mem_wr_data;
    logic [MW-1:0] mem_rd_data = '0;

    snapshot_mem_bridge #(
        .DATA_WIDTH(DW), .MEM_WIDTH(MW), .ADDR_WIDTH(AW), .ENTRY_WIDTH(EW),
        .SUB(1'b1), .BASE(32'h400), .WR_COMMIT_HIGH(1'b1), .TIMEOUT(TO), .RST_VALUE(RSTV)
    ) dut (
        .clk(clk), .rst(rst), .mst__fsm__sync_reset(sync_rst),
        .req_vld(req_vld), .addr(addr), .wr_en(wr_en), .rd_en(rd_en),
        .wr_data(wr_data), .rd_data(rd_data), .ack_vld(ack_vld), .err(err),
        .entry_vld(entry_vld), .entry_write_protect_en(wp),
        .mem_req_vld(mem_req_vld), .mem_ack_vld(mem_ack_vld), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { logic [31:0] rd; logic err; int cyc; } resp_t;
    typedef struct packed { logic [5:0] entry; logic rd; logic wr; logic chk; logic [71:0] data; int cyc; } memx_t;

    resp_t rq[$];
    memx_t mq[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    logic [MW-1:0] m_snap = '0;

    function automatic logic [31:0] part_of(input logic [71:0] s, input int p);
        logic [95:0] pad;
        pad = {24'h0, s};
        return pad[p*32 +: 32];
    endfunction

    function automatic logic [71:0] with_part(input logic [71:0] s, input int p, input logic [31:0] d);
        logic [95:0] pad;
        pad = {24'h0, s};
        pad[p*32 +: 32] = d;
        return pad[71:0];
    endfunction

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    initial begin : monitor
        logic  prev_req;
        resp_t r;
        memx_t m;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_vld) begin
                if (rq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_ack: got ack at cycle %0d, want no ack", cyc);
                end else begin
                    r = rq.pop_front();
                    check("ack_data", 128'({rd_data, err}), 128'({r.rd, r.err}));
                    check("ack_cycle", 128'(cyc), 128'(r.cyc));
                end
            end else begin
                check("rd_data_idle", 128'(rd_data), 128'(0));
            end
            if (mem_req_vld && !prev_req) begin
                if (mq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_mem_req: got request at cycle %0d, want none", cyc);
                end else begin
                    m = mq.pop_front();
                    check("mem_addr", 128'(mem_addr), 128'(m.entry));
                    check("mem_op", 128'({mem_rd_en, mem_wr_en}), 128'({m.rd, m.wr}));
                    check("mem_req_cycle", 128'(cyc), 128'(m.cyc));
                    if (m.chk) check("mem_wr_data", 128'(mem_wr_data), 128'(m.data));
                end
            end
            prev_req = mem_req_vld;
        end
    end

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    // Issue one request; lat = MEM_ACC cycle in which memory acks (beyond TO means late/stray).
    task automatic do_req(input logic [AW-1:0] a, input logic w, input logic r, input logic [31:0] d,
                          input logic ev, input logic p_wp, input int lat, input logic [71:0] md,
                          input logic extra);
        logic [AW-1:0] va;
        int            p;
        int            c;
        logic          memop;
        logic [71:0]   nw;
        resp_t         rs;
        va    = a - BASEA;
        p     = int'(va[3:2]);
        c     = cyc;
        memop = 1'b0;
        if (w) begin
            nw = with_part(m_snap, p, d);
            if (p == 2 && !p_wp) begin
                memop = 1'b1;
                mq.push_back('{entry: va[9:4], rd: 1'b0, wr: 1'b1, chk: 1'b1, data: nw, cyc: c + 1});
                if (lat <= TO) begin
                    m_snap = nw;
                    rs = '{rd: 32'h0, err: 1'b0, cyc: c + 2 + lat};
                end else rs = '{rd: 32'h0, err: 1'b1, cyc: c + 1 + TO + 1};
            end else begin
                m_snap = nw;
                rs = '{rd: 32'h0, err: 1'b0, cyc: c + 1};
            end
        end else if (r) begin
            if (p == 0 && ev) begin
                memop = 1'b1;
                mq.push_back('{entry: va[9:4], rd: 1'b1, wr: 1'b0, chk: 1'b0, data: 72'h0, cyc: c + 1});
                if (lat <= TO) begin
                    m_snap = md;
                    rs = '{rd: part_of(m_snap, 0), err: 1'b0, cyc: c + 2 + lat};
                end else rs = '{rd: 32'h0, err: 1'b1, cyc: c + 1 + TO + 1};
            end else if (p == 0) begin
                m_snap = RSTV;
                rs = '{rd: part_of(m_snap, 0), err: 1'b0, cyc: c + 1};
            end else begin
                rs = '{rd: part_of(m_snap, p), err: 1'b0, cyc: c + 1};
            end
        end else begin
            rs = '{rd: 32'h0, err: 1'b0, cyc: c + 1};
        end
        rq.push_back(rs);

        addr = a; wr_en = w; rd_en = r; wr_data = d; entry_vld = ev; wp = p_wp; req_vld = 1'b1;
        @(posedge clk); #1;
        req_vld = extra;
        if (extra) begin
            addr = AW'($urandom); wr_en = 1'($urandom); rd_en = 1'($urandom);
            wr_data = $urandom; entry_vld = 1'($urandom); wp = 1'($urandom);
        end
        if (memop) begin
            for (int i = 0; i < lat; i++) begin
                @(posedge clk); #1;
                req_vld = 1'b0;
            end
            mem_ack_vld = 1'b1; mem_rd_data = md;
            @(posedge clk); #1;
            mem_ack_vld = 1'b0; mem_rd_data = 72'({$urandom, $urandom, $urandom}); req_vld = 1'b0;
        end else begin
            @(posedge clk); #1;
            req_vld = 1'b0;
        end
        wait_until(rs.cyc + 1);
    endtask

    task automatic do_sync_abort(input logic [5:0] e);
        int c;
        c = cyc;
        mq.push_back('{entry: e, rd: 1'b1, wr: 1'b0, chk: 1'b0, data: 72'h0, cyc: c + 1});
        addr = BASEA + AW'({e, 4'h0}); wr_en = 1'b0; rd_en = 1'b1; entry_vld = 1'b1; wp = 1'b0;
        req_vld = 1'b1;
        @(posedge clk); #1; req_vld = 1'b0;
        @(posedge clk); #1; sync_rst = 1'b1;
        @(posedge clk); #1; sync_rst = 1'b0;
        @(negedge clk);
        check("sync_abort_mem_out", 128'({mem_req_vld, mem_rd_en, mem_wr_en, mem_addr}), 128'(0));
        @(posedge clk); #1;
        mem_ack_vld = 1'b1; mem_rd_data = 72'({$urandom, $urandom, $urandom});
        @(posedge clk); #1;
        mem_ack_vld = 1'b0;
        wait_until(c + 8);
    endtask

    task automatic do_rst_abort(input logic [31:0] d);
        int c;
        c = cyc;
        mq.push_back('{entry: 6'h2A, rd: 1'b0, wr: 1'b1, chk: 1'b1, data: with_part(m_snap, 2, d), cyc: c + 1});
        addr = BASEA + 12'h2A8; wr_en = 1'b1; rd_en = 1'b0; wr_data = d; wp = 1'b0; req_vld = 1'b1;
        @(posedge clk); #1; req_vld = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        #1;
        check("rst_abort_outputs",
              128'({mem_req_vld, mem_rd_en, mem_wr_en, mem_addr, ack_vld, err, rd_data}), 128'(0));
        m_snap = '0;
        @(posedge clk); #1; rst = 1'b0;
        wait_until(c + 9);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by 1 ms, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              128'({ack_vld, err, mem_req_vld, mem_rd_en, mem_wr_en, mem_addr, rd_data}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Partition reads after a memory fill, including the top (padded) partition.
        do_req(BASEA + 12'h000, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'hAB_1111_2222_3333_4444, 1'b0);
        do_req(BASEA + 12'h004, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h008, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        // Staging writes then a commit of the top partition.
        do_req(BASEA + 12'h000, 1'b1, 1'b0, 32'hA, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h004, 1'b1, 1'b0, 32'hB, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h008, 1'b1, 1'b0, 32'hC, 1'b1, 1'b0, 1, 72'h0, 1'b1);
        // Invalid entry read returns the reset value.
        do_req(BASEA + 12'h000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 0, 72'h0, 1'b0);
        // Timeout on a commit leaves the snapshot alone.
        do_req(BASEA + 12'h004, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h008, 1'b1, 1'b0, 32'h77, 1'b1, 1'b0, 9, 72'h0, 1'b0);
        do_req(BASEA + 12'h004, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h008, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        // Ack arriving in the timeout cycle wins; ack one cycle later is stray.
        do_req(BASEA + 12'h010, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, TO, 72'h12_3456_789A_BCDE_F012, 1'b0);
        do_req(BASEA + 12'h010, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, TO + 1, 72'hFF_FFFF_FFFF_FFFF_FFFF, 1'b0);
        // FSM abort, then normal service.
        do_sync_abort(6'h15);
        do_req(BASEA + 12'h004, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        // Protected commit stages only; both-enables is a write.
        do_req(BASEA + 12'h008, 1'b1, 1'b0, 32'h5A5A_5AC3, 1'b1, 1'b1, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h004, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h008, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        do_req(BASEA + 12'h004, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);
        // Asynchronous reset mid-access.
        do_rst_abort(32'h0000_00EE);
        do_req(BASEA + 12'h008, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 0, 72'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [AW-1:0] va;
            va = {2'($urandom), 6'($urandom), 2'($urandom_range(0, 2)), 2'($urandom)};
            do_req(va + BASEA, 1'($urandom), 1'($urandom), $urandom,
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                   int'($urandom_range(0, 6)), 72'({$urandom, $urandom, $urandom}),
                   ($urandom_range(0, 3) == 0));
        end

        repeat (5) @(posedge clk);
        check("resp_queue_drained", 128'(rq.size()), 128'(0));
        check("mem_queue_drained", 128'(mq.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
